// File: rtl/calc_port_if.sv
// Request/response bus of the calculator port: the master issues requests, the slave returns
// one response per accepted request.
interface calc_port_if;
    localparam int unsigned DW = 32;

    logic [3:0]    req_cmd;
    logic [3:0]    req_d1;
    logic [3:0]    req_d2;
    logic [3:0]    req_r1;
    logic [DW-1:0] req_data;
    logic [1:0]    req_tag;
    logic          req_busy;
    logic [1:0]    out_resp;
    logic [DW-1:0] out_data;
    logic [1:0]    out_tag;

    modport master (
        output req_cmd, req_d1, req_d2, req_r1, req_data, req_tag,
        input  req_busy, out_resp, out_data, out_tag
    );

    modport slave (
        input  req_cmd, req_d1, req_d2, req_r1, req_data, req_tag,
        output req_busy, out_resp, out_data, out_tag
    );
endinterface

// File: rtl/calc_port_responder.sv
// Calculator port responder: queues requests in a 4-deep FIFO and executes them in order
// against a 16 x 32 register file, returning a one-cycle tagged response per request.
module calc_port_responder (
    input  logic       clk,
    input  logic       reset,
    calc_port_if.slave bus
);
    localparam int unsigned DW         = 32;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PW         = 2;
    localparam int unsigned CW         = 3;
    localparam int unsigned NREGS      = 16;

    localparam logic [3:0] CMD_ADD   = 4'd1;
    localparam logic [3:0] CMD_SUB   = 4'd2;
    localparam logic [3:0] CMD_SHL   = 4'd5;
    localparam logic [3:0] CMD_SHR   = 4'd6;
    localparam logic [3:0] CMD_STORE = 4'd9;
    localparam logic [3:0] CMD_FETCH = 4'd10;

    localparam logic [1:0] RESP_OK  = 2'd1;
    localparam logic [1:0] RESP_ERR = 2'd2;

    typedef struct packed {
        logic [3:0]    cmd;
        logic [3:0]    d1;
        logic [3:0]    d2;
        logic [3:0]    r1;
        logic [DW-1:0] data;
        logic [1:0]    tag;
    } op_t;

    typedef enum logic [1:0] {IDLE, EXEC, EXTRA, RESP} state_t;

    state_t        state, state_next;
    op_t           fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_next;
    op_t           op;
    logic [DW-1:0] regs [NREGS];

    logic          push, pop, finish;
    logic [DW-1:0] opa, opb, res_data, wr_data;
    logic [DW:0]   sum;
    logic [1:0]    res_resp;
    logic          res_wr;

    // A request arriving while full is dropped even if a pop frees a slot on the same edge.
    assign push       = (bus.req_cmd != 4'd0) && !bus.req_busy;
    assign count_next = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (op.cmd == CMD_SHL || op.cmd == CMD_SHR) begin
                    state_next = EXTRA;
                end else begin
                    finish     = 1'b1;
                    state_next = RESP;
                end
            end
            EXTRA: begin
                finish     = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = EXEC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result of the operation currently held in the op register.
    always_comb begin
        opa      = regs[op.d1];
        opb      = regs[op.d2];
        sum      = (DW+1)'(opa) + (DW+1)'(opb);
        res_resp = RESP_ERR;
        res_data = '0;
        res_wr   = 1'b0;
        wr_data  = '0;
        case (op.cmd)
            CMD_ADD: begin
                if (!sum[DW]) begin
                    res_resp = RESP_OK;
                    res_data = sum[DW-1:0];
                    res_wr   = 1'b1;
                    wr_data  = sum[DW-1:0];
                end
            end
            CMD_SUB: begin
                if (opb <= opa) begin
                    res_resp = RESP_OK;
                    res_data = opa - opb;
                    res_wr   = 1'b1;
                    wr_data  = opa - opb;
                end
            end
            CMD_SHL, CMD_SHR: begin
                res_resp = RESP_OK;
                res_data = (op.cmd == CMD_SHL) ? (opa << opb[4:0]) : (opa >> opb[4:0]);
                res_wr   = 1'b1;
                wr_data  = res_data;
            end
            CMD_STORE: begin
                res_resp = RESP_OK;
                res_wr   = 1'b1;
                wr_data  = op.data;
            end
            CMD_FETCH: begin
                res_resp = RESP_OK;
                res_data = opa;
            end
            default: ;
        endcase
    end

    // FIFO storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{cmd: bus.req_cmd, d1: bus.req_d1, d2: bus.req_d2,
                                  r1: bus.req_r1, data: bus.req_data, tag: bus.req_tag};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            op           <= '0;
            bus.req_busy <= 1'b0;
            bus.out_resp <= '0;
            bus.out_data <= '0;
            bus.out_tag  <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (push) wr_ptr <= PW'(wr_ptr + 1'b1);
            if (pop) begin
                op     <= fifo_mem[rd_ptr];
                rd_ptr <= PW'(rd_ptr + 1'b1);
            end
            count        <= count_next;
            bus.req_busy <= (count_next == CW'(FIFO_DEPTH));
            // Register write lands with the response so the next op sees the new value.
            if (finish) begin
                bus.out_resp <= res_resp;
                bus.out_data <= res_data;
                bus.out_tag  <= op.tag;
                if (res_wr) regs[op.r1] <= wr_data;
            end else begin
                bus.out_resp <= '0;
                bus.out_data <= '0;
                bus.out_tag  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_calc_port_responder.sv
// Self-checking bench for calc_port_responder: directed scenarios plus random ops checked
// against an arithmetic reference model of the register file.
module tb_calc_port_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m_regs [16];
    logic [1:0]  last_resp;
    logic [31:0] last_data;

    calc_port_if bus ();

    calc_port_responder dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    endtask

    // Reference semantics computed with 64-bit arithmetic.
    task automatic model_op(input int cmd, input int d1, input int d2, input int r1,
                            input logic [31:0] data, output logic [1:0] r, output logic [31:0] d);
        longint unsigned a = 64'(m_regs[d1]);
        longint unsigned b = 64'(m_regs[d2]);
        r = 2'd2;
        d = 32'd0;
        case (cmd)
            1: if (a + b < 64'h1_0000_0000) begin r = 2'd1; d = 32'(a + b); m_regs[r1] = d; end
            2: if (a >= b) begin r = 2'd1; d = 32'(a - b); m_regs[r1] = d; end
            5: begin r = 2'd1; d = 32'((a << (b % 32)) & 64'hFFFF_FFFF); m_regs[r1] = d; end
            6: begin r = 2'd1; d = 32'(a >> (b % 32)); m_regs[r1] = d; end
            9: begin r = 2'd1; m_regs[r1] = data; end
            10: begin r = 2'd1; d = 32'(a); end
            default: ;
        endcase
    endtask

    task automatic drive(input int cmd, input int d1, input int d2, input int r1,
                         input logic [31:0] data, input int tag);
        bus.req_cmd  = 4'(cmd);
        bus.req_d1   = 4'(d1);
        bus.req_d2   = 4'(d2);
        bus.req_r1   = 4'(r1);
        bus.req_data = data;
        bus.req_tag  = 2'(tag);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge.
    task automatic exec_one(input int cmd, input int d1, input int d2, input int r1,
                            input logic [31:0] data, input int tag);
        logic [1:0]  er;
        logic [31:0] ed;
        int          k;
        int          lat;
        model_op(cmd, d1, d2, r1, data, er, ed);
        lat = (cmd == 5 || cmd == 6) ? 3 : 2;
        drive(cmd, d1, d2, r1, data, tag);
        @(negedge clk);
        bus.req_cmd = 4'd0;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (bus.out_resp != 2'd0) break;
        end
        last_resp = bus.out_resp;
        last_data = bus.out_data;
        check($sformatf("latency cmd%0d", cmd), 32'(k), 32'(lat));
        check($sformatf("resp cmd%0d", cmd), 32'(bus.out_resp), 32'(er));
        check($sformatf("data cmd%0d", cmd), bus.out_data, ed);
        check($sformatf("tag cmd%0d", cmd), 32'(bus.out_tag), 32'(tag));
        @(negedge clk);
        check("resp cleared", {bus.out_tag, bus.out_resp, bus.out_data[27:0]}, 32'd0);
    endtask

    initial begin
        logic [1:0]  q_resp [$];
        logic [1:0]  q_tag  [$];
        logic [31:0] v;

        drive(0, 0, 0, 0, 32'd0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        check("reset resp", 32'(bus.out_resp), 32'd0);
        check("reset data", bus.out_data, 32'd0);
        check("reset tag", 32'(bus.out_tag), 32'd0);
        check("reset busy", 32'(bus.req_busy), 32'd0);

        // First request on the first edge after reset release.
        rst_n = 1'b1;
        exec_one(9, 0, 0, 3, 32'd5, 0);
        exec_one(9, 0, 0, 4, 32'd7, 1);
        exec_one(1, 3, 4, 5, 32'd0, 2);
        check("add 3+4 data", last_data, 32'd12);
        exec_one(10, 5, 0, 0, 32'd0, 3);
        check("fetch r5", last_data, 32'd12);

        // Carry-out and underflow errors.
        exec_one(9, 0, 0, 1, 32'hFFFF_FFFF, 0);
        exec_one(9, 0, 0, 2, 32'd1, 1);
        exec_one(1, 1, 2, 6, 32'd0, 2);
        check("add carry resp", 32'(last_resp), 32'd2);
        exec_one(10, 6, 0, 0, 32'd0, 3);
        check("fetch r6", last_data, 32'd0);
        exec_one(2, 2, 1, 8, 32'd0, 0);
        check("sub underflow resp", 32'(last_resp), 32'd2);

        // Shifts take an extra cycle.
        exec_one(9, 0, 0, 1, 32'd1, 1);
        exec_one(9, 0, 0, 2, 32'd4, 2);
        exec_one(5, 1, 2, 7, 32'd0, 3);
        check("shl data", last_data, 32'd16);
        exec_one(6, 7, 2, 9, 32'd0, 0);
        check("shr data", last_data, 32'd1);

        // Invalid command leaves registers alone.
        exec_one(3, 1, 2, 7, 32'd0, 1);
        check("invalid resp", 32'(last_resp), 32'd2);
        exec_one(10, 7, 0, 0, 32'd0, 2);
        check("r7 after invalid", last_data, 32'd16);

        // Random ops with a mix of small and full-range operands.
        for (int n = 0; n < 60; n++) begin
            int c;
            int sel = $urandom_range(0, 12);
            case (sel)
                0, 1:    c = 1;
                2, 3:    c = 2;
                4:       c = 5;
                5:       c = 6;
                6, 7, 8: c = 9;
                9, 10:   c = 10;
                default: c = (sel == 11) ? 3 : 15;
            endcase
            v = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1000));
            exec_one(c, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                     v, $urandom_range(0, 3));
        end

        // Back-to-back stores from idle: FIFO fills, eighth is dropped.
        for (int i = 0; i < 8; i++) begin
            if (bus.out_resp != 2'd0) begin q_resp.push_back(bus.out_resp); q_tag.push_back(bus.out_tag); end
            if (i == 6) check("busy before 7th", 32'(bus.req_busy), 32'd0);
            if (i == 7) check("busy before 8th", 32'(bus.req_busy), 32'd1);
            v = $urandom;
            if (i < 7) m_regs[8 + i] = v;
            drive(9, 0, 0, 8 + i, v, i % 4);
            @(negedge clk);
        end
        bus.req_cmd = 4'd0;
        for (int t = 0; t < 30; t++) begin
            if (bus.out_resp != 2'd0) begin q_resp.push_back(bus.out_resp); q_tag.push_back(bus.out_tag); end
            @(negedge clk);
        end
        check("burst resp count", 32'(q_resp.size()), 32'd7);
        for (int j = 0; j < q_resp.size() && j < 7; j++) begin
            check($sformatf("burst resp %0d", j), 32'(q_resp[j]), 32'd1);
            check($sformatf("burst tag %0d", j), 32'(q_tag[j]), 32'(j % 4));
        end
        exec_one(10, 15, 0, 0, 32'd0, 0);
        exec_one(10, 14, 0, 0, 32'd0, 1);

        // Reset while an op is in EXEC and another is queued.
        drive(9, 0, 0, 2, 32'hABCD, 3);
        @(negedge clk);
        drive(9, 0, 0, 3, 32'h1234, 2);
        @(negedge clk);
        bus.req_cmd = 4'd0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("exec reset resp", 32'(bus.out_resp), 32'd0);
        check("exec reset busy", 32'(bus.req_busy), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("resp held in reset", 32'(bus.out_resp), 32'd0);
        end
        rst_n = 1'b1;
        exec_one(9, 0, 0, 5, 32'd77, 1);
        exec_one(10, 2, 0, 0, 32'd0, 2);
        exec_one(10, 8, 0, 0, 32'd0, 3);
        check("reg zero after reset", last_data, 32'd0);

        // Reset during a response cycle clears outputs immediately.
        drive(10, 5, 0, 0, 32'd0, 3);
        @(negedge clk);
        bus.req_cmd = 4'd0;
        repeat (2) @(negedge clk);
        check("resp before reset", 32'(bus.out_resp), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("resp reset data", bus.out_data, 32'd0);
        check("resp reset tag", 32'(bus.out_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exec_one(10, 5, 0, 0, 32'd0, 0);
        check("r5 zero after reset", last_data, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
